// File: rtl/sr_iterative_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_iterative_pkg
// Description : Shared FSM encodings, stage count and ALU shift opcodes for
//               the iterative right shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package sr_iterative_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NSTAGES = 5;

    localparam logic [3:0] ALU_SLL = 4'd1;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SRA = 4'd13;

    // Stage k shifts by 2^(4-k): 16, 8, 4, 2, 1.
    function automatic logic [4:0] stage_amount(input logic [2:0] sel);
        return 5'd16 >> sel;
    endfunction

endpackage : sr_iterative_pkg
`default_nettype wire

// File: rtl/sr_iterative_if.sv
`default_nettype none
// ============================================================================
// Module      : sr_iterative_if
// Description : Start/ready request and result bundle of the right shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sr_iterative_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic               arith;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   result;
    logic               result_rdy;
    logic               busy;

    modport master (
        output start, arith, data_in, shamt,
        input  result, result_rdy, busy
    );

    modport slave (
        input  start, arith, data_in, shamt,
        output result, result_rdy, busy
    );
endinterface : sr_iterative_if
`default_nettype wire

// File: rtl/sr_iterative_stage.sv
`default_nettype none
// ============================================================================
// Module      : sr_stage
// Description : One binary-weighted right-shift stage with explicit fill bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_stage
    import sr_iterative_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] value,
    input  wire logic [2:0]       sel,
    input  wire logic             en,
    input  wire logic             fill,
    output logic      [WIDTH-1:0] shifted
);
    logic [4:0]       w_amt;
    logic [WIDTH-1:0] w_sh;

    assign w_amt = stage_amount(sel);
    // Inverting around a logical shift pulls in ones instead of zeros.
    assign w_sh    = fill ? ~((~value) >> w_amt) : (value >> w_amt);
    assign shifted = en ? w_sh : value;
endmodule : sr_stage
`default_nettype wire

// File: rtl/sr_iterative.sv
`default_nettype none
// ============================================================================
// Module      : sr_iterative
// Description : Multicycle SRL/SRA, one binary-weighted stage per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_iterative
    import sr_iterative_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  wire logic  clock,
    input  wire logic  reset,
    sr_iterative_if.slave bus
);
    state_t             r_state;
    logic [2:0]         r_stage;
    logic [SHAMT_W-1:0] r_shamt;
    logic               r_arith;
    logic               r_sign;
    logic [WIDTH-1:0]   r_result;
    logic               r_result_rdy;
    logic               r_busy;

    logic               w_fill;
    logic               w_stage_en;
    logic [WIDTH-1:0]   w_stage_out;

    // Fill comes from the operand sign captured at start, never a partial result.
    assign w_fill = r_arith & r_sign;

    always_comb begin
        w_stage_en = 1'b0;
        case (r_stage)
            3'd0:    w_stage_en = r_shamt[4];
            3'd1:    w_stage_en = r_shamt[3];
            3'd2:    w_stage_en = r_shamt[2];
            3'd3:    w_stage_en = r_shamt[1];
            3'd4:    w_stage_en = r_shamt[0];
            default: w_stage_en = 1'b0;
        endcase
    end

    sr_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .value   (r_result),
        .sel     (r_stage),
        .en      (w_stage_en),
        .fill    (w_fill),
        .shifted (w_stage_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_stage      <= 3'd0;
            r_shamt      <= '0;
            r_arith      <= 1'b0;
            r_sign       <= 1'b0;
            r_result     <= '0;
            r_result_rdy <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_result_rdy <= 1'b0;
                    if (bus.start) begin
                        r_result <= bus.data_in;
                        r_sign   <= bus.data_in[WIDTH-1];
                        r_arith  <= bus.arith;
                        r_shamt  <= bus.shamt;
                        r_stage  <= 3'd0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_result <= w_stage_out;
                    r_stage  <= r_stage + 3'd1;
                    if (r_stage == 3'(NSTAGES - 1)) begin
                        r_result_rdy <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_DONE;
                    end
                end
                default: begin
                    r_result_rdy <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.result     = r_result;
    assign bus.result_rdy = r_result_rdy;
    assign bus.busy       = r_busy;
endmodule : sr_iterative
`default_nettype wire

// File: tb/tb_sr_iterative.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_iterative
// Description : Self-checking bench for sr_iterative against a shift model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_iterative;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    sr_iterative_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    sr_iterative #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic a);
        if (a) return 32'($signed(d) >>> s);
        return d >> s;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Issues one request and follows it to result_rdy; lat = -1 on timeout.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                          output logic [31:0] res, output int lat, output int busy_cnt);
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.shamt   = s;
        bus.arith   = a;
        tick(1);
        bus.start   = 1'b0;
        bus.data_in = $urandom;
        bus.shamt   = 5'($urandom);
        bus.arith   = 1'($urandom);
        lat = -1;
        busy_cnt = 0;
        res = 32'h0;
        for (int i = 0; i <= 12; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.result_rdy) begin
                lat = i;
                res = bus.result;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.arith = 1'b0; bus.data_in = '0; bus.shamt = '0;
        tick(3);
        reset = 1'b0;
        checks++;
        if (bus.result !== 32'h0 || bus.result_rdy !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: result=%h rdy=%b busy=%b required 00000000/0/0",
                     bus.result, bus.result_rdy, bus.busy);
        end
    endtask

    task automatic test_directed();
        logic [31:0] d_v [7] = '{32'h80000000, 32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                 32'h12345678, 32'h12345678, 32'h7FFFFFFF};
        logic [4:0]  s_v [7] = '{5'd31, 5'd31, 5'd16, 5'd16, 5'd0, 5'd0, 5'd4};
        logic        a_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] e_v [7] = '{32'hFFFFFFFF, 32'h00000001, 32'h0000F0F0, 32'hFFFFF0F0,
                                 32'h12345678, 32'h12345678, 32'h07FFFFFF};
        logic [31:0] res;
        int lat, bc;
        for (int i = 0; i < 7; i++) begin
            run_op(d_v[i], s_v[i], a_v[i], res, lat, bc);
            checks++;
            if (lat != 5 || bc != 5 || res !== e_v[i]) begin
                errors++;
                $display("FAIL directed_%0d: result=%h lat=%0d busy_cycles=%0d required %h/5/5",
                         i, res, lat, bc, e_v[i]);
            end
            tick(1);
            checks++;
            if (bus.result_rdy !== 1'b0 || bus.result !== e_v[i]) begin
                errors++;
                $display("FAIL hold_%0d: rdy=%b result=%h required 0/%h",
                         i, bus.result_rdy, bus.result, e_v[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d, res, exp;
        logic [4:0]  s;
        logic        a;
        int lat, bc;
        for (int i = 0; i < 24; i++) begin
            d = $urandom;
            s = 5'($urandom);
            a = 1'($urandom);
            if (i % 4 == 0) d[31] = 1'b1;
            exp = ref_shift(d, s, a);
            run_op(d, s, a, res, lat, bc);
            checks++;
            if (lat != 5 || res !== exp) begin
                errors++;
                $display("FAIL random_%0d: d=%h s=%0d a=%b result=%h lat=%0d required %h/5",
                         i, d, s, a, res, lat, exp);
            end
            tick(i % 3);
        end
    endtask

    task automatic test_start_during_shift();
        logic [31:0] exp, got;
        int pulses, lat;
        exp = ref_shift(32'h89ABCDEF, 5'd7, 1'b1);
        bus.start = 1'b1; bus.data_in = 32'h89ABCDEF; bus.shamt = 5'd7; bus.arith = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(1);
        bus.start = 1'b1; bus.data_in = 32'hFFFFFFFF; bus.shamt = 5'd1; bus.arith = 1'b1;
        tick(1);
        bus.start = 1'b0; bus.data_in = 32'h0BADF00D; bus.shamt = 5'd3; bus.arith = 1'b0;
        pulses = 0; lat = -1; got = '0;
        for (int i = 2; i <= 14; i++) begin
            if (bus.result_rdy) begin
                pulses++;
                if (lat < 0) begin lat = i; got = bus.result; end
            end
            tick(1);
        end
        checks++;
        if (pulses != 1 || lat != 5 || got !== exp) begin
            errors++;
            $display("FAIL start_in_shift: pulses=%0d lat=%0d result=%h required 1/5/%h",
                     pulses, lat, got, exp);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        int lat, bc, pulses;
        bus.start = 1'b1; bus.data_in = 32'hDEADBEEF; bus.shamt = 5'd9; bus.arith = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (bus.result !== 32'h0 || bus.result_rdy !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: result=%h rdy=%b busy=%b required 00000000/0/0",
                     bus.result, bus.result_rdy, bus.busy);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.result_rdy || bus.busy) pulses++;
            tick(1);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_abort: active_cycles=%0d required 0", pulses);
        end
        run_op(32'hC0000000, 5'd2, 1'b1, res, lat, bc);
        checks++;
        if (lat != 5 || res !== 32'hF0000000) begin
            errors++;
            $display("FAIL after_reset_op: result=%h lat=%0d required f0000000/5", res, lat);
        end
        tick(2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, bc;
        run_op(32'hA5A50000, 5'd4, 1'b0, res, lat, bc);
        checks++;
        if (lat != 5 || res !== 32'h0A5A5000) begin
            errors++;
            $display("FAIL b2b_first: result=%h lat=%0d required 0a5a5000/5", res, lat);
        end
        // Still in the result_rdy cycle: issue the next request immediately.
        run_op(32'h00000100, 5'd8, 1'b0, res, lat, bc);
        checks++;
        if (lat != 5 || bc != 5 || res !== 32'h00000001) begin
            errors++;
            $display("FAIL b2b_second: result=%h lat=%0d busy_cycles=%0d required 00000001/5/5",
                     res, lat, bc);
        end
        tick(2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_during_shift();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_sr_iterative
`default_nettype wire
